// File: rtl/dmem_responder.sv
// Word-organised data memory behind valid/ready request and response channels with LATENCY wait states.
// Optional feature macro: DMEM_ALIGN_CHK_EN rejects requests whose byte address is not word aligned.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high; the
    // producer holds valid and payload until that edge, and ready may be high before valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t              state;
    logic [3:0]          cnt;
    logic                lat_write;
    logic [ADDR_W+1:0]   lat_addr;
    logic [31:0]         lat_wdata;
    logic [3:0]          lat_be;

    logic [31:0]         mem [0:(1<<ADDR_W)-1];

    logic                accept;
    logic                acc_fire;
    logic                acc_write;
    logic [ADDR_W+1:0]   acc_addr;
    logic [31:0]         acc_wdata;
    logic [3:0]          acc_be;
    logic [ADDR_W-1:0]   acc_idx;
    logic                acc_err;
    logic                unused_bits;

    assign req_ready = (state == IDLE) & ~rst;
    assign rsp_valid = (state == RESP) & ~rst;
    assign accept    = req_valid & req_ready;
    assign dbg_state = state;

    // With zero wait states the access uses the request as presented on the accept edge.
    always_comb begin
        acc_fire  = 1'b0;
        acc_write = lat_write;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        if (LATENCY == 0) begin
            acc_fire  = accept;
            acc_write = req_write;
            acc_addr  = req_addr[ADDR_W+1:0];
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_fire  = (state == WAIT) && (cnt == 4'd0) && !rst;
        end
    end

    assign acc_idx = acc_addr[ADDR_W+1:2];

`ifdef DMEM_ALIGN_CHK_EN
    assign acc_err = (acc_addr[1:0] != 2'b00);
`else
    assign acc_err = 1'b0;
`endif

    assign unused_bits = ^{req_addr[31:ADDR_W+2], acc_addr[1:0]};

    // Memory contents survive reset, so the array has its own unreset process.
    always_ff @(posedge clk) begin
        if (acc_fire && acc_write && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (acc_fire) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr[ADDR_W+1:0];
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
